// File: rtl/debounced_edge_detector_pkg.sv
// Shared constants and helpers for the debounced edge detector.
// Edge-mode encodings and the pulse-qualification function.
package debounced_edge_detector_pkg;

  localparam logic [1:0] EDGE_MODE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_MODE_RISE = 2'b01;
  localparam logic [1:0] EDGE_MODE_FALL = 2'b10;
  localparam logic [1:0] EDGE_MODE_BOTH = 2'b11;

  // 1 when a flip in the given direction should raise a pulse.
  function automatic logic edge_fires(
    input logic [1:0] mode,
    input logic       rising
  );
    logic fire;
    fire = 1'b0;
    unique case (mode)
      EDGE_MODE_OFF:  fire = 1'b0;
      EDGE_MODE_RISE: fire = rising;
      EDGE_MODE_FALL: fire = ~rising;
      EDGE_MODE_BOTH: fire = 1'b1;
      default:        fire = 1'b0;
    endcase
    return fire;
  endfunction

endpackage

// File: rtl/debounced_edge_detector_sync.sv
// Multi-bit synchroniser: SYNC_STAGES flops per bit, cleared by rst.
// Ports: clk, rst (sync, active high), d_i raw bus, q_o last stage.
module debounced_edge_detector_sync #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounced_edge_detector.sv
// Multi-channel synchroniser + tick debouncer + mode-selectable edge pulse.
// Ports: clk, rst (sync, active high), signal_in raw bus, edge_mode
// (2 bits/channel), signal_out level, edge_detect_pulse, any_edge.
module debounced_edge_detector
  import debounced_edge_detector_pkg::*;
#(
  parameter int WIDTH          = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int STABLE_SAMPLES = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   signal_in,
  input  logic [2*WIDTH-1:0] edge_mode,
  output logic [WIDTH-1:0]   signal_out,
  output logic [WIDTH-1:0]   edge_detect_pulse,
  output logic               any_edge
);

  localparam int TW = $clog2(SAMPLE_CNT_MAX + 1);
  localparam int DW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CNT_MAX - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(STABLE_SAMPLES - 1);

  logic [WIDTH-1:0] sync;

  debounced_edge_detector_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (signal_in),
    .q_o (sync)
  );

  // Shared sample tick
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d     = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_d ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  // Per-channel debounce and edge qualification
  logic [WIDTH-1:0] lvl_q, lvl_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic             any_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [DW-1:0] cnt_q, cnt_d;
    logic          flip;

    // Counter only advances while the synced input disagrees
    // with the current level; any agreeing tick restarts it.
    always_comb begin
      cnt_d = cnt_q;
      flip  = 1'b0;
      if (tick_q) begin
        if (sync[i] == lvl_q[i]) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_d = '0;
          flip  = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign lvl_d[i]   = lvl_q[i] ^ flip;
    // Old level 0 means this flip is a rising one.
    assign pulse_d[i] = flip &
      edge_fires(edge_mode[2*i +: 2], ~lvl_q[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q   <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
    end else begin
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      any_q   <= |pulse_d;
    end
  end

  assign signal_out        = lvl_q;
  assign edge_detect_pulse = pulse_q;
  assign any_edge          = any_q;

endmodule

// File: tb/tb_debounced_edge_detector.sv
// Bench for debounced_edge_detector: directed scenarios plus
// randomized stimulus against a cycle-level behavioural model.
module tb_debounced_edge_detector;

  localparam int W  = 2;
  localparam int SY = 2;
  localparam int M  = 4;
  localparam int S  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   sig_in;
  logic [2*W-1:0] mode;
  logic [W-1:0]   sout;
  logic [W-1:0]   pulse;
  logic           any;

  always #5 clk = ~clk;

  debounced_edge_detector #(
    .WIDTH          (W),
    .SYNC_STAGES    (SY),
    .SAMPLE_CNT_MAX (M),
    .STABLE_SAMPLES (S)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .signal_in         (sig_in),
    .edge_mode         (mode),
    .signal_out        (sout),
    .edge_detect_pulse (pulse),
    .any_edge          (any)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: input seen SY edges late, debounce
  // decisions every M-th edge after reset release.
  logic [W-1:0] m_hist [SY];
  logic [W-1:0] m_out   = '0;
  logic [W-1:0] m_pulse = '0;
  logic         m_any   = 1'b0;
  int           m_cnt [W];
  int           m_k     = 0;

  task automatic model_edge();
    logic [W-1:0] sy;
    logic [W-1:0] np;
    logic         rising;
    if (rst) begin
      for (int j = 0; j < SY; j++) m_hist[j] = '0;
      for (int c = 0; c < W; c++) m_cnt[c] = 0;
      m_out   = '0;
      m_pulse = '0;
      m_any   = 1'b0;
      m_k     = 0;
    end else begin
      sy = m_hist[SY-1];
      np = '0;
      if (m_k > 0 && m_k % M == 0) begin
        for (int c = 0; c < W; c++) begin
          if (sy[c] == m_out[c]) begin
            m_cnt[c] = 0;
          end else if (m_cnt[c] == S - 1) begin
            m_cnt[c] = 0;
            rising   = ~m_out[c];
            m_out[c] = ~m_out[c];
            if ((rising && mode[2*c]) || (!rising && mode[2*c+1]))
              np[c] = 1'b1;
          end else begin
            m_cnt[c] = m_cnt[c] + 1;
          end
        end
      end
      for (int j = SY - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = sig_in;
      m_k++;
      m_pulse = np;
      m_any   = |np;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("signal_out", 32'(sout), 32'(m_out));
    check("pulse", 32'(pulse), 32'(m_pulse));
    check("any_edge", 32'(any), 32'(m_any));
  endtask

  int pcnt [W];
  int pfirst [W];
  int acnt;
  int bothcnt;

  task automatic watch(input int ncyc);
    for (int c = 0; c < W; c++) begin
      pcnt[c]   = 0;
      pfirst[c] = 0;
    end
    acnt    = 0;
    bothcnt = 0;
    for (int n = 1; n <= ncyc; n++) begin
      step();
      for (int c = 0; c < W; c++) begin
        if (pulse[c] === 1'b1) begin
          pcnt[c]++;
          if (pfirst[c] == 0) pfirst[c] = n;
        end
      end
      if (any === 1'b1) acnt++;
      if (pulse === 2'b11) bothcnt++;
    end
  endtask

  task automatic do_reset(input int n, input logic [W-1:0] v);
    rst    = 1'b1;
    sig_in = v;
    repeat (n) step();
    rst = 1'b0;
  endtask

  function automatic logic in_win(input int n);
    return (n >= 11) && (n <= 14);
  endfunction

  int hold;

  initial begin
    for (int j = 0; j < SY; j++) m_hist[j] = '0;
    for (int c = 0; c < W; c++) m_cnt[c] = 0;
    rst    = 1'b1;
    sig_in = '0;
    mode   = 4'b0101;

    // Reset with inputs held high
    rst    = 1'b1;
    sig_in = 2'b11;
    for (int n = 0; n < 3; n++) begin
      step();
      check("rst_out", 32'(sout), 32'd0);
      check("rst_pulse", 32'(pulse), 32'd0);
      check("rst_any", 32'(any), 32'd0);
    end
    rst = 1'b0;
    watch(20);
    check("rst_ch0_cnt", 32'(pcnt[0]), 32'd1);
    check("rst_ch1_cnt", 32'(pcnt[1]), 32'd1);
    check("rst_ch0_win", 32'(in_win(pfirst[0])), 32'd1);
    check("rst_ch1_win", 32'(in_win(pfirst[1])), 32'd1);

    // Clean rise on ch0
    do_reset(2, 2'b00);
    sig_in = 2'b01;
    watch(30);
    check("rise_cnt", 32'(pcnt[0]), 32'd1);
    check("rise_win", 32'(in_win(pfirst[0])), 32'd1);
    check("rise_ch1", 32'(pcnt[1]), 32'd0);
    check("rise_any", 32'(acnt), 32'd1);
    check("rise_lvl", 32'(sout[0]), 32'd1);

    // Glitch shorter than the debounce time
    do_reset(2, 2'b00);
    sig_in = 2'b01;
    watch(6);
    check("glitch_a", 32'(pcnt[0]), 32'd0);
    sig_in = 2'b00;
    watch(40);
    check("glitch_b", 32'(pcnt[0]), 32'd0);
    check("glitch_lvl", 32'(sout[0]), 32'd0);

    // Both-edge mode then fall-only mode on ch1
    do_reset(2, 2'b00);
    mode   = 4'b1101;
    sig_in = 2'b10;
    watch(30);
    check("both_rise", 32'(pcnt[1]), 32'd1);
    sig_in = 2'b00;
    watch(30);
    check("both_fall", 32'(pcnt[1]), 32'd1);
    check("both_lvl", 32'(sout[1]), 32'd0);
    mode   = 4'b1001;
    sig_in = 2'b10;
    watch(30);
    check("fall_rise", 32'(pcnt[1]), 32'd0);
    check("fall_rlvl", 32'(sout[1]), 32'd1);
    sig_in = 2'b00;
    watch(30);
    check("fall_fall", 32'(pcnt[1]), 32'd1);

    // Simultaneous rise on both channels
    mode = 4'b0101;
    do_reset(2, 2'b00);
    sig_in = 2'b11;
    watch(30);
    check("simul_both", 32'(bothcnt), 32'd1);
    check("simul_any", 32'(acnt), 32'd1);

    // Reset in the middle of a debounce
    do_reset(2, 2'b00);
    sig_in = 2'b01;
    watch(7);
    check("mid_pre", 32'(pcnt[0]), 32'd0);
    rst = 1'b1;
    step();
    check("mid_rst", 32'(pulse), 32'd0);
    rst = 1'b0;
    watch(20);
    check("mid_cnt", 32'(pcnt[0]), 32'd1);
    check("mid_win", 32'(in_win(pfirst[0])), 32'd1);

    // Randomized traffic against the model
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 3) == 0) mode = 4'($urandom);
      if ($urandom_range(0, 1) == 0) sig_in[0] = ~sig_in[0];
      if ($urandom_range(0, 1) == 0) sig_in[1] = ~sig_in[1];
      rst  = ($urandom_range(0, 39) == 0);
      hold = $urandom_range(1, 25);
      step();
      rst = 1'b0;
      for (int h = 1; h < hold; h++) begin
        if ($urandom_range(0, 7) == 0) mode = 4'($urandom);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debounced_edge_detector.md
Name: debounced_edge_detector

Overview:
Multi-channel input conditioner: per channel a synchroniser, then a sample-tick-based debouncer, then a mode-selectable edge detector. It generalises the single-cycle rising-edge detector in width, adds a per-channel edge mode (rising, falling, both or off), and adds glitch rejection. It sits between raw board inputs (buttons, switches, async strobes) and control FSMs that need a clean level and a one-cycle event pulse.

Parameters:
WIDTH, 2, number of independent channels.
SYNC_STAGES, 2, flip-flops in each synchroniser chain; legal values are 2 or more.
SAMPLE_CNT_MAX, 62500, clk cycles per debounce sample tick; legal values are 1 or more, and 1 means a tick every cycle.
STABLE_SAMPLES, 200, consecutive differing ticks needed before the debounced level flips; legal values are 1 or more.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
signal_in  input  WIDTH  raw asynchronous inputs.
edge_mode  input  2*WIDTH  per-channel mode; bits [2i+1:2i] control channel i; 00 off, 01 rising, 10 falling, 11 both.
signal_out  output  WIDTH  debounced level.
edge_detect_pulse  output  WIDTH  one-cycle event pulse per channel.
any_edge  output  1  registered OR-reduction of the next-state edge_detect_pulse, so it asserts in the same cycle as edge_detect_pulse.

Behaviour:
- Reset (rst high at posedge) clears the following to 0: sync chains, tick counter, sample_tick, per-channel counters, signal_out, edge_detect_pulse and any_edge.
- Reset mid-debounce discards partial counts and generates no pulse.
- Synchroniser: sync_i is the last stage of the SYNC_STAGES chain on signal_in[i].
- Tick generator: one counter shared by all channels.
  - It counts 0 to SAMPLE_CNT_MAX-1 and wraps.
  - Registered sample_tick is high for exactly one cycle per wrap.
  - Counter width is $clog2(SAMPLE_CNT_MAX+1).
- Debounce, evaluated per channel at each posedge where sample_tick=1:
  - If sync_i equals signal_out[i], the counter is cleared.
  - Otherwise, if counter == STABLE_SAMPLES-1, a flip occurs: signal_out[i] toggles and the counter clears.
  - Otherwise the counter increments.
  - The counter never exceeds STABLE_SAMPLES-1. Counter width is $clog2(STABLE_SAMPLES+1).
  - When sample_tick=0, counters and levels hold.
- Edge detection: edge_detect_pulse[i] is registered and follows a decided rule.
  - At the posedge where a flip occurs, the next value is 1 when either:
    - the flip is 0 to 1 and edge_mode[2i]=1, or
    - the flip is 1 to 0 and edge_mode[2i+1]=1.
  - The next value is 0 in every other cycle.
  - The pulse is therefore high exactly in the first cycle signal_out shows the new level, and always exactly one cycle wide.
  - edge_mode is sampled only at the flip posedge. Changing it at other times never creates or cancels a pulse.
  - Mode 00 still updates signal_out but never pulses.
- Latency: let the first posedge that samples a new, stable input level be cycle 0. The pulse asserts in a cycle within [SYNC_STAGES + (STABLE_SAMPLES-1)*SAMPLE_CNT_MAX + 1, SYNC_STAGES + STABLE_SAMPLES*SAMPLE_CNT_MAX].
- Glitch rejection: an input pulse shorter than (STABLE_SAMPLES-1)*SAMPLE_CNT_MAX cycles never flips signal_out.
- Channels are fully independent. Simultaneous flips on several channels pulse in the same cycle.
- Input held high through reset release: signal_out starts at 0, so a rising flip and pulse occur after the debounce time.

Decomposition:
- Shared constants package/include holds EDGE_MODE_OFF=2'b00, EDGE_MODE_RISE=2'b01, EDGE_MODE_FALL=2'b10, EDGE_MODE_BOTH=2'b11.
- Natural sub-module: synchronizer (parameter WIDTH and SYNC_STAGES), instantiated once for the whole bus.
- The tick generator and the per-channel debounce/edge logic use a generate loop in the top module.

Test Plan:
All scenarios use WIDTH=2, SYNC_STAGES=2, SAMPLE_CNT_MAX=4, STABLE_SAMPLES=3, and edge_mode=4'b0101 unless stated.
- Reset: hold rst for 3 cycles with signal_in=2'b11 → signal_out=0, edge_detect_pulse=0 and any_edge=0 during reset. After release, ch0 and ch1 each give exactly one rising pulse within cycles 11..14.
- Clean rise: hold signal_in[0] at 1 for 30 cycles → edge_detect_pulse[0] is high for exactly 1 cycle within cycles 11..14, signal_out[0] is 1 from that cycle, and any_edge matches.
- Glitch: signal_in[0] high for 6 cycles then low → edge_detect_pulse stays 0 and signal_out[0] stays 0 over 40 cycles.
- Mode both on ch1: edge_mode[3:2]=11, rise ch1, hold 30 cycles, then fall → two single-cycle pulses, one per transition. With edge_mode[3:2]=10, only the fall pulses.
- Simultaneous: raise both channels on the same posedge → edge_detect_pulse=2'b11 in one cycle and any_edge=1 for one cycle.
- Reset mid-debounce: raise ch0 and assert rst at cycle 8 for 1 cycle → no pulse at cycles 11..14. The pulse then occurs within 11..14 cycles after rst release.
